// File: rtl/ballot_collector.sv
// rtl/ballot_collector.sv - ballot collector: dedupes voter ballots and presents the packed vote bus
module ballot_collector #(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [M-1:0]           in_voter,
  input  logic [N-1:0]           in_choice,
  input  logic                   close,
  output logic                   dup,
  output logic [(2**M)*N-1:0]    vote,
  output logic                   vote_valid,
  input  logic                   vote_ack,
  output logic [2**M-1:0]        voted_mask,
  output logic [M:0]             count
);

  localparam int SLOTS = 2**M;
  localparam int VW    = SLOTS * N;
  // Count value that the next fresh ballot turns into a full electorate.
  localparam logic [M:0] LAST = (M+1)'(SLOTS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [VW-1:0]     vote_next;
  logic [SLOTS-1:0]  mask_next;
  logic [M:0]        count_next;
  logic              dup_next;
  logic              accept;
  logic              seen;
  logic              fresh;

  // Ballots are only taken while collecting; no ready while the bus is presented.
  assign in_ready = (state == COLLECT);
  assign accept   = in_valid & in_ready;
  assign seen     = voted_mask[in_voter];
  assign fresh    = accept & ~seen;

  // Next-state and next-data decode for the collect/present cycle.
  always_comb begin
    state_next = state;
    vote_next  = vote;
    mask_next  = voted_mask;
    count_next = count;
    dup_next   = 1'b0;
    case (state)
      COLLECT: begin
        if (accept && seen) begin
          dup_next = 1'b1;
        end
        if (fresh) begin
          for (int i = 0; i < SLOTS; i++) begin
            if (in_voter == i[M-1:0]) begin
              vote_next[i*N +: N] = in_choice;
            end
          end
          mask_next[in_voter] = 1'b1;
          count_next          = count + (M+1)'(1);
        end
        // The ballot arriving with close is applied before presenting.
        if ((fresh && (count == LAST)) || close) begin
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (vote_ack) begin
          state_next = COLLECT;
          vote_next  = '0;
          mask_next  = '0;
          count_next = '0;
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  // State and all registered outputs; reset discards any partial election.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      vote       <= '0;
      voted_mask <= '0;
      count      <= '0;
      dup        <= 1'b0;
      vote_valid <= 1'b0;
    end else begin
      state      <= state_next;
      vote       <= vote_next;
      voted_mask <= mask_next;
      count      <= count_next;
      dup        <= dup_next;
      vote_valid <= (state_next == PRESENT);
    end
  end

endmodule
